// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line in, byte/status out, optional read strobe.
// The slave modport is the receiver; the master modport is the line driver / byte consumer.
`timescale 1ns/1ps

interface uart_rx_if;
    logic       uart_rx;
    logic [7:0] uart_dat_o;
    logic       uart_valid_o;
    logic       uart_frame_err_o;
    logic       uart_rd_i;
    logic       uart_overrun_o;

    modport slave (
        input  uart_rx,
        input  uart_rd_i,
        output uart_dat_o,
        output uart_valid_o,
        output uart_frame_err_o,
        output uart_overrun_o
    );

    modport master (
        output uart_rx,
        output uart_rd_i,
        input  uart_dat_o,
        input  uart_valid_o,
        input  uart_frame_err_o,
        input  uart_overrun_o
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled from a fractional-accumulator tick, with framing-error detect.
// Optional macro UART_RX_HOLD_EN: valid becomes a level held until read, with a sticky overrun flag.
`timescale 1ns/1ps

module uart_rx #(
    parameter int unsigned CLK_HZ = 27000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned ACC_W  = 32
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave rx_bus
);

    localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(16 * BAUD);
    localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(CLK_HZ);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [1:0]       sync_r;
    logic             rx_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_sum_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             tick_s;

    state_t           state_r;
    logic [3:0]       phase_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       dat_r;
    logic             valid_r;
    logic             ferr_r;
    logic             overrun_r;

    assign rx_s = sync_r[1];

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_bus.uart_rx};
        end
    end

    // Fractional tick: one tick per CLK_HZ/(16*BAUD) clocks on average.
    always_comb begin
        acc_sum_s = acc_r + ACC_INC;
        if (acc_sum_s >= ACC_MOD) begin
            tick_s     = 1'b1;
            acc_next_s = acc_sum_s - ACC_MOD;
        end else begin
            tick_s     = 1'b0;
            acc_next_s = acc_sum_s;
        end
    end

    // Tick accumulator, free-running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_next_s;
        end
    end

    // Receive FSM with registered byte/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            phase_r   <= 4'd0;
            idx_r     <= 3'd0;
            shift_r   <= 8'd0;
            dat_r     <= 8'd0;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            ferr_r <= 1'b0;
`ifdef UART_RX_HOLD_EN
            if (rx_bus.uart_rd_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
`else
            valid_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_r <= ST_START;
                        phase_r <= 4'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (phase_r == 4'd7) begin
                            // Mid start bit: a line back high here was only a glitch.
                            if (!rx_s) begin
                                state_r <= ST_DATA;
                                phase_r <= 4'd0;
                                idx_r   <= 3'd0;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end else begin
                        phase_r <= phase_r;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (phase_r == 4'd15) begin
                            phase_r <= 4'd0;
                            shift_r <= {rx_s, shift_r[7:1]};
                            if (idx_r == 3'd7) begin
                                state_r <= ST_STOP;
                            end else begin
                                idx_r <= idx_r + 3'd1;
                            end
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end else begin
                        phase_r <= phase_r;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (phase_r == 4'd15) begin
                            phase_r <= 4'd0;
                            if (rx_s) begin
                                state_r <= ST_IDLE;
`ifdef UART_RX_HOLD_EN
                                // A read in the same cycle frees the holding register.
                                if (!valid_r || rx_bus.uart_rd_i) begin
                                    dat_r   <= shift_r;
                                    valid_r <= 1'b1;
                                end else begin
                                    overrun_r <= 1'b1;
                                end
`else
                                dat_r   <= shift_r;
                                valid_r <= 1'b1;
`endif
                            end else begin
                                ferr_r  <= 1'b1;
                                state_r <= ST_BREAK;
                            end
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end else begin
                        phase_r <= phase_r;
                    end
                end
                ST_BREAK: begin
                    // Hold here while the line stays low so a break is not read as 0x00 bytes.
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    phase_r <= 4'd0;
                    idx_r   <= 3'd0;
                end
            endcase
        end
    end

    assign rx_bus.uart_dat_o       = dat_r;
    assign rx_bus.uart_valid_o     = valid_r;
    assign rx_bus.uart_frame_err_o = ferr_r;

`ifdef UART_RX_HOLD_EN
    assign rx_bus.uart_overrun_o = overrun_r;
`else
    logic unused_rd_s;
    logic unused_ovr_s;
    assign unused_rd_s           = rx_bus.uart_rd_i;
    assign unused_ovr_s          = overrun_r;
    assign rx_bus.uart_overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences and a random
// stream checked against a byte-queue model. Clock ratio gives 20 clocks per bit (1.25 per tick).
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int  CLK_HZ = 2000000;
    localparam int  BAUD   = 100000;
    localparam real BIT_NS = 200.0;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .ACC_W (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_bus(u_if)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: record each rising edge of valid, frame-error pulses and over-long valids.
    logic [7:0] got_q[$];
    int   ev_cnt     = 0;
    int   ferr_cnt   = 0;
    int   ferr_cyc   = 0;
    int   wide_cnt   = 0;
    logic valid_prev = 1'b0;
    logic ferr_prev  = 1'b0;
    logic rd_prev    = 1'b0;

    always @(negedge clk) begin
        valid_prev <= u_if.uart_valid_o;
        ferr_prev  <= u_if.uart_frame_err_o;
        rd_prev    <= u_if.uart_rd_i;
        if (u_if.uart_valid_o && !valid_prev) begin
            got_q.push_back(u_if.uart_dat_o);
            ev_cnt <= ev_cnt + 1;
        end
`ifdef UART_RX_HOLD_EN
        if (u_if.uart_valid_o && valid_prev && rd_prev) wide_cnt <= wide_cnt + 1;
`else
        if (u_if.uart_valid_o && valid_prev) wide_cnt <= wide_cnt + 1;
`endif
        if (u_if.uart_frame_err_o) ferr_cyc <= ferr_cyc + 1;
        if (u_if.uart_frame_err_o && !ferr_prev) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input int skew_pm);
        realtime bt;
        bt = BIT_NS * (1000.0 + real'(skew_pm)) / 1000.0;
        u_if.uart_rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            u_if.uart_rx = d[i];
            #(bt);
        end
        u_if.uart_rx = stop;
        #(bt);
    endtask

    task automatic idle_bits(input int n);
        u_if.uart_rx = 1'b1;
        #(BIT_NS * real'(n));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         skew;
        int         exp_ev;
        logic [7:0] exp_dat;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[9];
    int   n0, f0, total_ferr_exp;
    logic [7:0] exp_q[$];

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1,   0, 1, 8'h55, 0};
        vecs[1] = '{8'h00, 1'b1,   0, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1,   0, 1, 8'hFF, 0};
        vecs[3] = '{8'hA5, 1'b0,   0, 0, 8'hFF, 1};
        vecs[4] = '{8'h5A, 1'b1,  20, 1, 8'h5A, 0};
        vecs[5] = '{8'h5A, 1'b1, -20, 1, 8'h5A, 0};
        vecs[6] = '{8'h81, 1'b1,  10, 1, 8'h81, 0};
        vecs[7] = '{8'h3C, 1'b0, -10, 0, 8'h81, 1};
        vecs[8] = '{8'hC3, 1'b1,   0, 1, 8'hC3, 0};
        total_ferr_exp = 0;

        reset          = 1'b1;
        u_if.uart_rx   = 1'b1;
        u_if.uart_rd_i = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_dat",     u_if.uart_dat_o,       32'h0);
        check("reset_valid",   u_if.uart_valid_o,     32'h0);
        check("reset_ferr",    u_if.uart_frame_err_o, 32'h0);
        check("reset_overrun", u_if.uart_overrun_o,   32'h0);
        reset = 1'b0;
        idle_bits(2);

        // Table of single frames.
        for (int v = 0; v < 9; v++) begin
            n0 = ev_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].skew);
            idle_bits(3);
            @(negedge clk);
            check($sformatf("vec%0d_events", v), ev_cnt - n0, vecs[v].exp_ev);
            check($sformatf("vec%0d_dat", v), u_if.uart_dat_o, vecs[v].exp_dat);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_valid_low", v), u_if.uart_valid_o, 32'h0);
            total_ferr_exp += vecs[v].exp_ferr;
        end

        // Back-to-back 0x00 then 0xFF with no idle gap.
        n0 = ev_cnt;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle_bits(3);
        @(negedge clk);
        check("b2b_events", ev_cnt - n0, 32'd2);
        if (ev_cnt - n0 == 2) begin
            check("b2b_first",  got_q[n0],     32'h00);
            check("b2b_second", got_q[n0 + 1], 32'hFF);
        end

        // Quarter-bit glitch rejected, then a normal frame still received.
        n0 = ev_cnt;
        f0 = ferr_cnt;
        u_if.uart_rx = 1'b0;
        #(BIT_NS / 4.0);
        idle_bits(3);
        @(negedge clk);
        check("glitch_events", ev_cnt - n0, 32'd0);
        check("glitch_ferr",   ferr_cnt - f0, 32'd0);
        send_frame(8'h96, 1'b1, 0);
        idle_bits(3);
        @(negedge clk);
        check("post_glitch_dat", u_if.uart_dat_o, 32'h96);

        // Stop bit low, line held low three more bits, then 0x3C.
        n0 = ev_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0, 0);
        #(BIT_NS * 3.0);
        @(negedge clk);
        check("break_dat_kept", u_if.uart_dat_o, 32'h96);
        idle_bits(2);
        send_frame(8'h3C, 1'b1, 0);
        idle_bits(3);
        @(negedge clk);
        check("break_ferr",   ferr_cnt - f0, 32'd1);
        check("break_events", ev_cnt - n0, 32'd1);
        check("break_dat",    u_if.uart_dat_o, 32'h3C);
        total_ferr_exp += 1;

        // Reset asserted from bit 4 of 0x81 to the end of that frame, then 0xC3.
        n0 = ev_cnt;
        u_if.uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            u_if.uart_rx = (8'h81 >> i) & 8'h01;
            if (i == 4) reset = 1'b1;
            #(BIT_NS);
            if (i == 4) begin
                check("rst_mid_dat",     u_if.uart_dat_o,       32'h0);
                check("rst_mid_valid",   u_if.uart_valid_o,     32'h0);
                check("rst_mid_ferr",    u_if.uart_frame_err_o, 32'h0);
                check("rst_mid_overrun", u_if.uart_overrun_o,   32'h0);
            end
        end
        u_if.uart_rx = 1'b1;
        #(BIT_NS);
        reset = 1'b0;
        idle_bits(2);
        send_frame(8'hC3, 1'b1, 0);
        idle_bits(3);
        @(negedge clk);
        check("rst_events", ev_cnt - n0, 32'd1);
        if (ev_cnt - n0 == 1) check("rst_byte", got_q[n0], 32'hC3);

        // Read-strobe behaviour.
        n0 = ev_cnt;
        @(negedge clk);
        u_if.uart_rd_i = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        idle_bits(1);
        send_frame(8'h22, 1'b1, 0);
        idle_bits(3);
        @(negedge clk);
`ifdef UART_RX_HOLD_EN
        check("hold_events",  ev_cnt - n0, 32'd1);
        check("hold_dat",     u_if.uart_dat_o, 32'h11);
        check("hold_valid",   u_if.uart_valid_o, 32'h1);
        check("hold_overrun", u_if.uart_overrun_o, 32'h1);
        u_if.uart_rd_i = 1'b1;
        @(negedge clk);
        check("hold_rd_clear", u_if.uart_valid_o, 32'h0);
        check("hold_ovr_sticky", u_if.uart_overrun_o, 32'h1);
`else
        check("pulse_events",  ev_cnt - n0, 32'd2);
        check("pulse_dat",     u_if.uart_dat_o, 32'h22);
        check("pulse_valid",   u_if.uart_valid_o, 32'h0);
        check("pulse_overrun", u_if.uart_overrun_o, 32'h0);
        u_if.uart_rd_i = 1'b1;
`endif

        // Baud tolerance: 0x5A sixteen times at alternating +/-2% skew.
        n0 = ev_cnt;
        for (int k = 0; k < 16; k++) begin
            send_frame(8'h5A, 1'b1, (k % 2 == 0) ? 20 : -20);
            idle_bits(1);
        end
        idle_bits(2);
        @(negedge clk);
        check("tol_events", ev_cnt - n0, 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (n0 + k < got_q.size()) check($sformatf("tol_byte%0d", k), got_q[n0 + k], 32'h5A);
        end

        // Random stream against a queue model of delivered bytes.
        n0 = ev_cnt;
        f0 = ferr_cnt;
        exp_q.delete();
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            logic       ok;
            int         sk, gap;
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 7) != 0);
            sk  = int'($urandom_range(0, 40)) - 20;
            gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            if (ok) exp_q.push_back(d);
            else total_ferr_exp += 1;
            send_frame(d, ok, sk);
            if (gap > 0) idle_bits(gap);
            else u_if.uart_rx = 1'b1;
        end
        idle_bits(3);
        @(negedge clk);
        check("rand_events", ev_cnt - n0, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (n0 + k < got_q.size()) check($sformatf("rand_byte%0d", k), got_q[n0 + k], exp_q[k]);
        end
        if (exp_q.size() > 0) check("rand_last_dat", u_if.uart_dat_o, exp_q[exp_q.size() - 1]);

        check("ferr_pulses_total", ferr_cnt, total_ferr_exp);
        check("ferr_cycles_total", ferr_cyc, total_ferr_exp);
        check("valid_width", wide_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
